// File: rtl/quad_timing_pkg.sv
// Shared constants for the quad pulse timing blocks: FSM encoding, quad state
// boundaries, default counter width and a channel one-hot helper.
package quad_timing_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int N_CH_DEFAULT  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;

  localparam logic [1:0] QUAD_LAST  = 2'b11;
  localparam logic [1:0] QUAD_FIRST = 2'b00;

  function automatic logic [N_CH_DEFAULT-1:0] chan_onehot(input logic [1:0] ch);
    logic [N_CH_DEFAULT-1:0] oh;
    oh     = '0;
    oh[ch] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/quad_down_counter.sv
// Loadable down-counter shared by the DELAY and PULSE phases; stops at zero
// and flags both zero and the final (==1) count.
module quad_down_counter
  import quad_timing_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign last  = (count_q == CNT_W'(1));

endmodule

// File: rtl/quad_phase_pulser.sv
// Fires one delayed, timed pulse on the channel named by each new quad state.
// Optional QUAD_CYCLE_COUNT_EN enables the completed-quad-cycle counter.
module quad_phase_pulser
  import quad_timing_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int N_CH  = N_CH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       state,
  input  logic             initial_state,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  output logic [N_CH-1:0]  chan_out,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] cycle_count
);

  logic [1:0]       state_q;
  logic [1:0]       fsm_q, fsm_d;
  logic [1:0]       ch_q, ch_d;
  logic [CNT_W-1:0] wid_q, wid_d;
  logic [N_CH-1:0]  chan_q, chan_d;
  logic             overrun_q, overrun_d;

  logic             cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [CNT_W-1:0] cnt_val, cnt_count;
  logic             change_event;
  logic             busy_w;

  assign change_event = (state != state_q) && enable && !initial_state;
  assign busy_w       = (fsm_q != ST_IDLE);

  quad_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_comb begin
    fsm_d     = fsm_q;
    ch_d      = ch_q;
    wid_d     = wid_q;
    chan_d    = chan_q;
    overrun_d = overrun_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = delay;
    // A new change always wins: abort whatever is running and restart timing.
    if (change_event) begin
      overrun_d = overrun_q | busy_w;
      ch_d      = state;
      wid_d     = width;
      cnt_load  = 1'b1;
      cnt_val   = delay;
      chan_d    = '0;
      fsm_d     = ST_DELAY;
    end else begin
      case (fsm_q)
        ST_DELAY: begin
          if (cnt_zero) begin
            if (wid_q == '0) begin
              fsm_d = ST_IDLE;
            end else begin
              fsm_d    = ST_PULSE;
              cnt_load = 1'b1;
              cnt_val  = wid_q;
              chan_d   = chan_onehot(ch_q);
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_PULSE: begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            fsm_d  = ST_IDLE;
            chan_d = '0;
          end
        end
        default: begin
          fsm_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= 2'b00;
      fsm_q     <= ST_IDLE;
      ch_q      <= 2'b00;
      wid_q     <= '0;
      chan_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state;
      fsm_q     <= fsm_d;
      ch_q      <= ch_d;
      wid_q     <= wid_d;
      chan_q    <= chan_d;
      overrun_q <= overrun_d;
    end
  end

  assign chan_out = chan_q;
  assign busy     = busy_w;
  assign overrun  = overrun_q;

`ifdef QUAD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_q, cycle_d;

  always_comb begin
    cycle_d = cycle_q;
    if (change_event && (state_q == QUAD_LAST) && (state == QUAD_FIRST)) begin
      cycle_d = cycle_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_count = cycle_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_quad_phase_pulser.sv
// Scoreboard bench for quad_phase_pulser: a timeline model predicts each
// cycle's outputs, a monitor process pops and compares them.
`timescale 1ns/1ps
module tb_quad_phase_pulser;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [1:0]       state = 2'b00;
  logic             initial_state = 1'b0;
  logic [CNT_W-1:0] delay = '0;
  logic [CNT_W-1:0] width = '0;
  logic [3:0]       chan_out;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] cycle_count;

  always #200 clk = ~clk;

  quad_phase_pulser dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .state         (state),
    .initial_state (initial_state),
    .delay         (delay),
    .width         (width),
    .chan_out      (chan_out),
    .busy          (busy),
    .overrun       (overrun),
    .cycle_count   (cycle_count)
  );

  typedef struct {
    longint           t;
    logic [3:0]       chan;
    logic             busy;
    logic             ovr;
    logic [CNT_W-1:0] cc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: each accepted change defines a job with absolute pulse window times.
  longint           t = 0;
  logic [1:0]       m_prev = 2'b00;
  bit               m_valid = 0;
  logic [1:0]       m_ch = 2'b00;
  longint           m_start = 0;
  longint           m_end = 0;
  bit               m_ovr = 0;
  logic [CNT_W-1:0] m_cc = '0;
  logic [1:0]       cur_s = 2'b00;

  task automatic step(input bit r, input bit e, input bit i, input logic [1:0] s,
                      input int d, input int w);
    exp_t x;
    bit   ev;
    @(negedge clk);
    rst = r; enable = e; initial_state = i; state = s;
    delay = d[CNT_W-1:0]; width = w[CNT_W-1:0];
    cur_s = s;
    t++;
    if (r) begin
      m_prev = 2'b00; m_valid = 0; m_ovr = 0; m_cc = '0;
    end else begin
      ev = (s != m_prev) && e && !i;
      if (ev) begin
        if (m_valid && t <= m_end) m_ovr = 1;
`ifdef QUAD_CYCLE_COUNT_EN
        if (m_prev == 2'b11 && s == 2'b00) m_cc = m_cc + 1'b1;
`endif
        m_valid = 1;
        m_ch    = s;
        m_start = t + d + 1;
        m_end   = m_start + w;
      end
      m_prev = s;
    end
    x.t    = t;
    x.chan = (m_valid && t >= m_start && t < m_end) ? (4'b0001 << m_ch) : 4'b0000;
    x.busy = m_valid && (t < m_end);
    x.ovr  = m_ovr;
    x.cc   = m_cc;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, cur_s, 7, 3);
  endtask

  task automatic chk(input string name, input longint tt, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, tt, act, req);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("chan_out", x.t, 32'(chan_out), 32'(x.chan));
        chk("busy", x.t, 32'(busy), 32'(x.busy));
        chk("overrun", x.t, 32'(overrun), 32'(x.ovr));
        chk("cycle_count", x.t, 32'(cycle_count), 32'(x.cc));
      end
    end
  end

  initial begin : stim
    repeat (3) step(1, 1, 0, 2'd0, 0, 0);
    step(0, 1, 0, 2'd1, 3, 2);  idle(8);   // delay 3, width 2
    step(0, 1, 0, 2'd2, 0, 1);  idle(4);   // delay 0, width 1
    step(0, 1, 0, 2'd3, 5, 0);  idle(8);   // width 0: busy only
    step(0, 1, 0, 2'd1, 10, 4); idle(2);   // overrun case
    step(0, 1, 0, 2'd2, 10, 4); idle(20);
    step(1, 1, 0, 2'd0, 0, 0);
    step(0, 1, 1, 2'd1, 1, 2);  step(0, 1, 1, 2'd2, 1, 2); idle(4);
    step(0, 1, 0, 2'd3, 1, 2);  idle(6);
    step(0, 0, 0, 2'd0, 1, 2);  step(0, 0, 0, 2'd1, 1, 2); idle(4);
    step(0, 1, 0, 2'd2, 1, 2);  idle(6);
    step(1, 1, 0, 2'd0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      for (int q = 1; q <= 4; q++) begin
        step(0, 1, 0, 2'(q), 0, 1);
        idle(3);
      end
    end
    step(0, 1, 0, 2'd2, 1, 6);  idle(3);
    step(1, 1, 0, 2'd2, 1, 6);  idle(3);   // reset mid-pulse
    step(0, 1, 0, 2'd3, 300, 3); idle(310);
    for (int n = 0; n < 3000; n++) begin
      bit r, e, i;
      logic [1:0] s;
      r = ($urandom_range(0, 249) == 0);
      e = ($urandom_range(0, 9) != 0);
      i = ($urandom_range(0, 14) == 0);
      s = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : cur_s;
      step(r, e, i, s, $urandom_range(0, 12), $urandom_range(0, 5));
    end
    idle(2);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
